// File: rtl/resfuzzy_host_tx_if.sv
// Bundle of the upstream byte stream, the engine-side parallel bus
// and the risk result path for resfuzzy_host_tx.
interface resfuzzy_host_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       ss;
    logic [7:0] data_bus;
    logic [7:0] risk_in;
    logic [7:0] risk_out;
    logic       risk_valid;
    logic       busy;

    modport slave (
        input  in_data, in_valid, abort, risk_in,
        output in_ready, ss, data_bus, risk_out, risk_valid, busy
    );

    modport master (
        output in_data, in_valid, abort, risk_in,
        input  in_ready, ss, data_bus, risk_out, risk_valid, busy
    );
endinterface

// File: rtl/resfuzzy_host_tx.sv
// Host transmitter: buffers a sensor frame, drives it under ss,
// then captures the engine's risk byte after a fixed latency.
module resfuzzy_host_tx #(
    parameter int NUM_BYTES  = 4,
    parameter int SETUP_CYC  = 1,
    parameter int HOLD_CYC   = 2,
    parameter int RESULT_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    resfuzzy_host_tx_if.slave  bus
);

    localparam int IW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int MAX1 = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAXC = (MAX1 > RESULT_LAT) ? MAX1 : RESULT_LAT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_BYTES - 1);
    localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LAT_END   = CW'(RESULT_LAT - 1);

    typedef enum logic [1:0] {
        FILL,
        SETUP,
        SEND,
        WAIT
    } state_t;

    state_t        r_state;
    logic [7:0]    r_buf [NUM_BYTES];
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_ss;
    logic [7:0]    r_bus;
    logic [7:0]    r_risk_out;
    logic          r_risk_valid;
    logic          r_busy;

    logic          w_accept;
    logic          w_last;
    logic [7:0]    w_buf0;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_last   = (r_wr_idx == LAST_IDX);
    // A one-byte frame writes buf[0] on the same edge SETUP starts.
    assign w_buf0   = (NUM_BYTES == 1) ? bus.in_data : r_buf[0];

    always_ff @(posedge clk) begin
        if (w_accept && !bus.abort && r_state == FILL)
            r_buf[r_wr_idx] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_wr_idx     <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_ss         <= 1'b1;
            r_bus        <= 8'h00;
            r_risk_out   <= 8'h00;
            r_risk_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_risk_valid <= 1'b0;
            if (bus.abort) begin
                r_state    <= FILL;
                r_wr_idx   <= '0;
                r_idx      <= '0;
                r_cnt      <= '0;
                r_in_ready <= 1'b1;
                r_ss       <= 1'b1;
                r_bus      <= 8'h00;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    FILL: begin
                        r_in_ready <= 1'b1;
                        if (w_accept) begin
                            if (w_last) begin
                                r_wr_idx   <= '0;
                                r_cnt      <= '0;
                                r_state    <= SETUP;
                                r_in_ready <= 1'b0;
                                r_ss       <= 1'b0;
                                r_bus      <= w_buf0;
                                r_busy     <= 1'b1;
                            end else begin
                                r_wr_idx <= r_wr_idx + IW'(1);
                            end
                        end
                    end
                    SETUP: begin
                        if (r_cnt == SETUP_END) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_state <= SEND;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    SEND: begin
                        if (r_cnt == HOLD_END) begin
                            r_cnt <= '0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= WAIT;
                                r_ss    <= 1'b1;
                                r_bus   <= 8'h00;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                                r_bus <= r_buf[r_idx + IW'(1)];
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    WAIT: begin
                        if (r_cnt == LAT_END) begin
                            r_cnt        <= '0;
                            r_state      <= FILL;
                            r_risk_out   <= bus.risk_in;
                            r_risk_valid <= 1'b1;
                            r_in_ready   <= 1'b1;
                            r_busy       <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= FILL;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.ss         = r_ss;
    assign bus.data_bus   = r_bus;
    assign bus.risk_out   = r_risk_out;
    assign bus.risk_valid = r_risk_valid;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_resfuzzy_host_tx.sv
// Directed bench for resfuzzy_host_tx: default instance plus a
// one-byte, single-cycle-timing instance.
module tb_resfuzzy_host_tx;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    resfuzzy_host_tx_if u_if ();
    resfuzzy_host_tx_if u_if1 ();

    resfuzzy_host_tx u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    resfuzzy_host_tx #(
        .NUM_BYTES  (1),
        .SETUP_CYC  (1),
        .HOLD_CYC   (1),
        .RESULT_LAT (1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        u_if.in_valid = 1'b1;
        u_if.in_data  = b;
        tick();
    endtask

    // Starts in the first ss-low cycle of a default-parameter frame.
    task automatic tx_check(input logic [31:0] w, input logic [7:0] rk);
        logic [7:0] e;
        int         b;
        for (int k = 0; k < 9; k++) begin
            b = (k == 0) ? 0 : (k - 1) / 2;
            e = w[31 - 8 * b -: 8];
            chk("ss_low", 32'(u_if.ss), 0);
            chk("bus_byte", 32'(u_if.data_bus), 32'(e));
            chk("rdy_low", 32'(u_if.in_ready), 0);
            tick();
        end
        chk("ss_rise", 32'(u_if.ss), 1);
        chk("bus_zero", 32'(u_if.data_bus), 0);
        chk("busy_wait", 32'(u_if.busy), 1);
        repeat (3) begin
            tick();
            chk("no_rv", 32'(u_if.risk_valid), 0);
            chk("ss_wait", 32'(u_if.ss), 1);
        end
        tick();
        chk("rv_pulse", 32'(u_if.risk_valid), 1);
        chk("risk_out", 32'(u_if.risk_out), 32'(rk));
        chk("rdy_back", 32'(u_if.in_ready), 1);
        chk("busy_idle", 32'(u_if.busy), 0);
        tick();
        chk("rv_once", 32'(u_if.risk_valid), 0);
        chk("risk_hold", 32'(u_if.risk_out), 32'(rk));
    endtask

    initial begin
        logic [6:0]  vp;
        logic [31:0] sw;
        int          n;

        rst_n          = 1'b0;
        u_if.in_data   = 8'h00;
        u_if.in_valid  = 1'b0;
        u_if.abort     = 1'b0;
        u_if.risk_in   = 8'h00;
        u_if1.in_data  = 8'h00;
        u_if1.in_valid = 1'b0;
        u_if1.abort    = 1'b0;
        u_if1.risk_in  = 8'h00;

        repeat (2) tick();
        chk("rst_ss", 32'(u_if.ss), 1);
        chk("rst_bus", 32'(u_if.data_bus), 0);
        chk("rst_risk", 32'(u_if.risk_out), 0);
        chk("rst_rv", 32'(u_if.risk_valid), 0);
        chk("rst_busy", 32'(u_if.busy), 0);
        chk("rst_rdy", 32'(u_if.in_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 32'(u_if.in_ready), 1);

        // Basic back-to-back frame
        u_if.risk_in = 8'hA5;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        u_if.in_valid = 1'b0;
        tx_check(32'h11223344, 8'hA5);

        // Abort while byte 2 is on the bus
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        push(8'hC4);
        u_if.in_valid = 1'b0;
        repeat (5) tick();
        chk("pre_abort_bus", 32'(u_if.data_bus), 32'hC3);
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        chk("abort_ss", 32'(u_if.ss), 1);
        chk("abort_bus", 32'(u_if.data_bus), 0);
        chk("abort_busy", 32'(u_if.busy), 0);
        chk("abort_rdy", 32'(u_if.in_ready), 1);
        chk("abort_risk", 32'(u_if.risk_out), 32'hA5);
        repeat (5) begin
            chk("abort_no_rv", 32'(u_if.risk_valid), 0);
            tick();
        end

        // Partial fill discarded, byte coincident with abort dropped
        push(8'h99);
        u_if.in_data = 8'h98;
        u_if.abort   = 1'b1;
        tick();
        u_if.abort = 1'b0;
        u_if.risk_in = 8'h5C;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        u_if.in_valid = 1'b0;
        tx_check(32'h01020304, 8'h5C);

        // Upstream stalls
        vp = 7'b1011001;
        sw = 32'h5A6B7C8D;
        n  = 0;
        u_if.risk_in = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            u_if.in_valid = vp[i];
            u_if.in_data  = vp[i] ? sw[31 - 8 * n -: 8] : 8'hEE;
            tick();
            if (vp[i]) n++;
            if (i < 6) chk("stall_ss_idle", 32'(u_if.ss), 1);
        end
        u_if.in_valid = 1'b0;
        tx_check(32'h5A6B7C8D, 8'h3C);

        // Asynchronous reset mid-frame
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        push(8'hDD);
        u_if.in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_ss_low", 32'(u_if.ss), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ss", 32'(u_if.ss), 1);
        chk("arst_bus", 32'(u_if.data_bus), 0);
        chk("arst_busy", 32'(u_if.busy), 0);
        chk("arst_risk", 32'(u_if.risk_out), 0);
        chk("arst_rdy", 32'(u_if.in_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_rdy", 32'(u_if.in_ready), 1);
        chk("rel_busy", 32'(u_if.busy), 0);
        chk("rel_ss", 32'(u_if.ss), 1);
        chk("rel_risk", 32'(u_if.risk_out), 0);

        // One-byte frames, unit timing, back to back
        u_if1.risk_in  = 8'h42;
        u_if1.in_valid = 1'b1;
        u_if1.in_data  = 8'h77;
        tick();
        u_if1.in_data = 8'h78;
        chk("sw_s1_ss", 32'(u_if1.ss), 0);
        chk("sw_s1_bus", 32'(u_if1.data_bus), 32'h77);
        chk("sw_s1_rdy", 32'(u_if1.in_ready), 0);
        tick();
        chk("sw_s2_ss", 32'(u_if1.ss), 0);
        chk("sw_s2_bus", 32'(u_if1.data_bus), 32'h77);
        tick();
        chk("sw_w_ss", 32'(u_if1.ss), 1);
        chk("sw_w_bus", 32'(u_if1.data_bus), 0);
        chk("sw_w_busy", 32'(u_if1.busy), 1);
        chk("sw_w_rv", 32'(u_if1.risk_valid), 0);
        tick();
        chk("sw_rv", 32'(u_if1.risk_valid), 1);
        chk("sw_risk", 32'(u_if1.risk_out), 32'h42);
        chk("sw_idle_ss", 32'(u_if1.ss), 1);
        chk("sw_rdy", 32'(u_if1.in_ready), 1);
        tick();
        u_if1.in_valid = 1'b0;
        u_if1.risk_in  = 8'h43;
        chk("sw2_ss", 32'(u_if1.ss), 0);
        chk("sw2_bus", 32'(u_if1.data_bus), 32'h78);
        chk("sw2_rv", 32'(u_if1.risk_valid), 0);
        repeat (3) tick();
        chk("sw2_rv_pulse", 32'(u_if1.risk_valid), 1);
        chk("sw2_risk", 32'(u_if1.risk_out), 32'h43);
        chk("dut0_idle", 32'(u_if.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resfuzzy_host_tx.md
Name: resfuzzy_host_tx

Overview:
- Host-side transmitter for the resfuzzy sensor-frame interface.
- Collects a frame of sensor bytes from an upstream valid/ready stream and buffers it.
- Drives the frame onto the 8-bit parallel data bus, framed by the select line `ss`.
- After a fixed latency, captures the fuzzy risk byte returned by the engine and presents it upstream with a one-cycle strobe.

Parameters:
- NUM_BYTES, 4, bytes per frame (for example temperature, humidity, gas, pressure); minimum 1, maximum 16.
- SETUP_CYC, 1, cycles `ss` is asserted with byte 0 on the bus before the byte slots begin; minimum 1.
- HOLD_CYC, 2, cycles each byte is held on `data_bus`; minimum 1.
- RESULT_LAT, 4, cycles between `ss` release and sampling of `risk_in`; minimum 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, 8, upstream sensor byte.
- in_valid, input, 1, `in_data` is valid.
- in_ready, output, 1, block accepts a byte this cycle.
- abort, input, 1, synchronous cancel of the current frame.
- ss, output, 1, frame select, active-low; 1 when idle.
- data_bus, output, 8, byte driven to the fuzzy engine.
- risk_in, input, 8, risk byte returned by the engine.
- risk_out, output, 8, last captured risk value.
- risk_valid, output, 1, one-cycle strobe when `risk_out` updates.
- busy, output, 1, high in SETUP, SEND and WAIT.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - State is FILL; write index, byte index and cycle counter are 0.
  - `ss`=1, `data_bus`=0, `risk_out`=0, `risk_valid`=0, `busy`=0.
  - `in_ready` is 0 while `rst_n` is low and 1 from the first cycle after release.
  - Buffer contents are don't-care.
- FILL:
  - `in_ready`=1.
  - When `in_valid` and `in_ready` are both high, store `in_data` at buf[wr_idx] and increment wr_idx.
  - Acceptance of the byte at wr_idx = NUM_BYTES-1 moves the state to SETUP on the next cycle and clears wr_idx.
- SETUP:
  - `in_ready`=0, `ss`=0, `data_bus`=buf[0].
  - Lasts exactly SETUP_CYC cycles, then goes to SEND with byte index 0.
- SEND:
  - `ss`=0, `data_bus`=buf[idx].
  - Each byte is held exactly HOLD_CYC cycles, then idx increments.
  - After the last byte's hold completes, go to WAIT.
  - `ss` is low for exactly SETUP_CYC + NUM_BYTES×HOLD_CYC consecutive cycles per frame.
- WAIT:
  - `ss`=1, `data_bus`=0.
  - Counts RESULT_LAT cycles.
  - On the final WAIT cycle, `risk_out` is loaded from `risk_in` (registered), so the new value is visible in the next cycle.
  - In that next cycle `risk_valid`=1 for exactly one cycle and the state is FILL with `in_ready`=1.
- Bus rules:
  - `data_bus` is always 0 whenever `ss`=1; no glitch between frames.
  - `ss` and `data_bus` are driven directly from registers.
- `risk_out` holds its value until the next successful capture.
- `abort`:
  - Synchronous; has priority over all transitions.
  - Next cycle: FILL, wr_idx=0, `ss`=1, `data_bus`=0, no `risk_valid`, `risk_out` unchanged.
  - Bytes already accepted in FILL are discarded.
  - `abort` and an accepted handshake in the same cycle: the byte is dropped.
- `in_valid` outside FILL is ignored; no byte is accepted or lost, because `in_ready`=0.
- Reset asserted mid-frame forces `ss`=1 and `data_bus`=0 immediately (asynchronous), regardless of clock.
- Counter widths: sized for the parameter maximums; no wrap occurs within legal parameter ranges.

Test Plan:
- Basic frame (defaults), bytes 0x11, 0x22, 0x33, 0x44 streamed back-to-back:
  - `in_ready` drops the cycle after the 4th accept.
  - `ss`=0 for exactly 9 cycles; bus sequence is 0x11 ×3, 0x22 ×2, 0x33 ×2, 0x44 ×2.
  - Then `ss`=1 with bus 0x00.
- Result capture: `risk_in`=0xA5 held during WAIT:
  - 4 cycles after `ss` rises, `risk_out`=0xA5 and `risk_valid` pulses for 1 cycle.
  - `in_ready`=1 in the same cycle.
- Upstream stalls: `in_valid` toggled 1,0,0,1,1,0,1:
  - Exactly 4 bytes are captured, in order.
  - The frame matches the accepted data; `ss` stays 1 until the 4th accept.
- Abort mid-SEND during byte 2:
  - Next cycle `ss`=1, `data_bus`=0, `busy`=0.
  - No `risk_valid`; `risk_out` keeps its prior value (0xA5).
  - A new frame 0x01..0x04 then transmits correctly.
- Async reset mid-frame: pull `rst_n` low between clock edges:
  - `ss`=1 and `data_bus`=0 immediately.
  - After release, the block is in FILL with `risk_out`=0x00.
- Parameter sweep (NUM_BYTES=1, HOLD_CYC=1, SETUP_CYC=1, RESULT_LAT=1):
  - `ss` is low for 2 cycles.
  - `risk_valid` pulses 1 cycle after WAIT.
  - Back-to-back frames show at least 1 idle `ss`=1 cycle plus the FILL time between them.
